// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges stall requests and runs
// the two-phase exception entry (freeze, then flush+redirect). Define CTRL_WDOG_EN for the stall watchdog.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h00000020,
    parameter logic [31:0] ERET_CODE  = 32'h0000000e,
    parameter logic [15:0] WDOG_LIMIT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        wdog_o
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [5:0]  stall_vec;

    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        state_d   = ST_RUN;
        flush_d   = 1'b0;
        new_pc_d  = new_pc_q;
        stall_vec = 6'b000000;
        if (state_q == ST_RUN) begin
            if (excepttype_i != 32'd0) begin
                // Freeze everything up to MEM so the faulting instruction never retires.
                stall_vec = 6'b011111;
                flush_d   = 1'b1;
                new_pc_d  = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                state_d   = ST_FLUSH;
            end else if (stallreq_mem_i) begin
                stall_vec = 6'b011111;
            end else if (stallreq_ex_i) begin
                stall_vec = 6'b001111;
            end else if (stallreq_id_i) begin
                stall_vec = 6'b000111;
            end else if (stallreq_if_i) begin
                stall_vec = 6'b000011;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            flush_q  <= 1'b0;
            new_pc_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign stall_o  = rst ? 6'b000000 : stall_vec;
    assign flush_o  = flush_q & ~rst;
    assign new_pc_o = rst ? 32'd0 : new_pc_q;

`ifdef CTRL_WDOG_EN
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_q, wdog_d;
    logic        stalled;

    assign stalled = (state_q == ST_RUN) && (stall_vec != 6'b000000);

    always_comb begin
        wdog_cnt_d = 16'd0;
        if (stalled) begin
            wdog_cnt_d = (wdog_cnt_q >= WDOG_LIMIT) ? wdog_cnt_q : wdog_cnt_q + 16'd1;
        end
        wdog_d = wdog_q | (stalled && (wdog_cnt_d == WDOG_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q <= 16'd0;
            wdog_q     <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_q     <= wdog_d;
        end
    end

    assign wdog_o = wdog_q & ~rst;
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_o            = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stall priority, exception/ERET flush sequencing,
// reset during FLUSH and the optional watchdog (built with WDOG_LIMIT = 8).
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        wdog_o;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_ctrl #(
        .EXC_VECTOR(32'h00000020),
        .ERET_CODE (32'h0000000e),
        .WDOG_LIMIT(16'd8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if_i (stallreq_if_i),
        .stallreq_id_i (stallreq_id_i),
        .stallreq_ex_i (stallreq_ex_i),
        .stallreq_mem_i(stallreq_mem_i),
        .excepttype_i  (excepttype_i),
        .cp0_epc_i     (cp0_epc_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .new_pc_o      (new_pc_o),
        .wdog_o        (wdog_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input logic f, input logic d, input logic e, input logic m);
        stallreq_if_i  = f;
        stallreq_id_i  = d;
        stallreq_ex_i  = e;
        stallreq_mem_i = m;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        stallreq_if_i  = 1'b0;
        stallreq_id_i  = 1'b0;
        stallreq_ex_i  = 1'b1;
        stallreq_mem_i = 1'b1;
        excepttype_i   = 32'h00000008;
        cp0_epc_i      = 32'h12345678;

        // Reset with active inputs: all outputs must read 0.
        step(2);
        check("rst_stall", {26'd0, stall_o}, 32'h0);
        check("rst_flush", {31'd0, flush_o}, 32'h0);
        check("rst_newpc", new_pc_o, 32'h0);
        check("rst_wdog", {31'd0, wdog_o}, 32'h0);

        rst          = 1'b0;
        excepttype_i = 32'h0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_stall", {26'd0, stall_o}, 32'h0);
        step();
        check("idle_flush", {31'd0, flush_o}, 32'h0);

        // Single requesters and priority, all same-cycle.
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        check("ex_stall", {26'd0, stall_o}, 32'h0000000f);
        check("ex_flush", {31'd0, flush_o}, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0);
        check("if_stall", {26'd0, stall_o}, 32'h00000003);
        set_req(1'b0, 1'b1, 1'b0, 1'b0);
        check("id_stall", {26'd0, stall_o}, 32'h00000007);
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        check("mem_stall", {26'd0, stall_o}, 32'h0000001f);
        set_req(1'b0, 1'b1, 1'b0, 1'b1);
        check("id_mem_prio", {26'd0, stall_o}, 32'h0000001f);
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        check("if_ex_prio", {26'd0, stall_o}, 32'h0000000f);
        set_req(1'b1, 1'b1, 1'b0, 1'b0);
        check("if_id_prio", {26'd0, stall_o}, 32'h00000007);

        // Plain exception over an EX stall.
        excepttype_i = 32'h00000008;
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        check("exc_stall", {26'd0, stall_o}, 32'h0000001f);
        check("exc_noflush", {31'd0, flush_o}, 32'h0);
        step();
        excepttype_i = 32'h0;
        #1;
        check("exc_flush", {31'd0, flush_o}, 32'h1);
        check("exc_flush_stall", {26'd0, stall_o}, 32'h0);
        check("exc_newpc", new_pc_o, 32'h00000020);
        step();
        check("exc_after_flush", {31'd0, flush_o}, 32'h0);
        check("exc_newpc_held", new_pc_o, 32'h00000020);
        check("exc_after_stall", {26'd0, stall_o}, 32'h0000000f);

        // ERET redirects to EPC.
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        excepttype_i = 32'h0000000e;
        cp0_epc_i    = 32'hbfc00100;
        #1;
        check("eret_stall", {26'd0, stall_o}, 32'h0000001f);
        step();
        excepttype_i = 32'h0;
        #1;
        check("eret_flush", {31'd0, flush_o}, 32'h1);
        check("eret_newpc", new_pc_o, 32'hbfc00100);
        step();
        check("eret_after", {31'd0, flush_o}, 32'h0);

        // Exception held: flush pattern 0,1,0,1; flush cycle ignores stall requests.
        excepttype_i = 32'h00000004;
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        check("hold_c1_flush", {31'd0, flush_o}, 32'h0);
        step();
        check("hold_c2_flush", {31'd0, flush_o}, 32'h1);
        check("hold_c2_stall", {26'd0, stall_o}, 32'h0);
        check("hold_c2_newpc", new_pc_o, 32'h00000020);
        step();
        check("hold_c3_flush", {31'd0, flush_o}, 32'h0);
        check("hold_c3_stall", {26'd0, stall_o}, 32'h0000001f);
        step();
        check("hold_c4_flush", {31'd0, flush_o}, 32'h1);

        // Reset while in FLUSH: no partial redirect.
        rst = 1'b1;
        step();
        check("rstfl_flush", {31'd0, flush_o}, 32'h0);
        check("rstfl_stall", {26'd0, stall_o}, 32'h0);
        check("rstfl_newpc", new_pc_o, 32'h0);
        rst          = 1'b0;
        excepttype_i = 32'h0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("rstfl_post_flush", {31'd0, flush_o}, 32'h0);
        check("rstfl_post_newpc", new_pc_o, 32'h0);

        // Watchdog.
`ifdef CTRL_WDOG_EN
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        step(7);
        check("wdog_7", {31'd0, wdog_o}, 32'h0);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("wdog_idle", {31'd0, wdog_o}, 32'h0);
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        step(7);
        check("wdog_7b", {31'd0, wdog_o}, 32'h0);
        step();
        check("wdog_8", {31'd0, wdog_o}, 32'h1);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        step(3);
        check("wdog_sticky", {31'd0, wdog_o}, 32'h1);
        rst = 1'b1;
        step();
        check("wdog_rst", {31'd0, wdog_o}, 32'h0);
        rst = 1'b0;
`else
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        step(20);
        check("wdog_off", {31'd0, wdog_o}, 32'h0);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
